// File: rtl/abs_pkg.sv
// Shared definitions for the absolute-value frame accumulator slice.
package abs_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Narrowest sum that cannot overflow for a frame of count full-scale magnitudes.
   function automatic int min_sum_w(input int count);
      return DATA_W + $clog2(count);
   endfunction

endpackage

// File: rtl/absolute_value.sv
// Two's-complement magnitude; the result is read as unsigned so 8'h80 maps to 128.
module absolute_value #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] number,
   output logic [WIDTH-1:0] abs_out
);

   always_comb begin
      abs_out = number[WIDTH-1] ? (~number + WIDTH'(1)) : number;
   end

endmodule

// File: rtl/abs_frame_accumulator.sv
// Accepts one frame of signed samples, accumulates the magnitude sum and tracks
// the largest magnitude with its index; results hold until the next start.
module abs_frame_accumulator
   import abs_pkg::*;
#(
   parameter  int COUNT = 8,
   parameter  int SUM_W = 11,
   localparam int IDX_W = $clog2(COUNT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              busy,
   output logic              done,
   output logic [SUM_W-1:0]  sum,
   output logic [DATA_W-1:0] max_abs,
   output logic [IDX_W-1:0]  max_idx
);

   if (COUNT < 2 || COUNT > 256) begin : g_bad_count
      $error("abs_frame_accumulator: COUNT must be in 2..256");
   end
   if (SUM_W < min_sum_w(COUNT)) begin : g_bad_sum_w
      $error("abs_frame_accumulator: SUM_W too narrow for COUNT");
   end

   localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    cnt_q;
   logic [SUM_W-1:0]    sum_q;
   logic [DATA_W-1:0]   max_q;
   logic [IDX_W-1:0]    idx_q;
   logic [DATA_W-1:0]   mag;
   logic                accept;
   logic                clear;

   absolute_value #(.WIDTH(DATA_W)) u_abs (
      .number  (in_data),
      .abs_out (mag)
   );

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      clear    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               clear   = 1'b1;
            end
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      accept = in_ready && in_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sum_q <= '0;
         max_q <= '0;
         idx_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
         sum_q <= '0;
         max_q <= '0;
         idx_q <= '0;
      end else if (accept) begin
         cnt_q <= cnt_q + IDX_W'(1);
         sum_q <= sum_q + SUM_W'(mag);
         // Strict compare keeps the earliest index on ties.
         if (mag > max_q) begin
            max_q <= mag;
            idx_q <= cnt_q;
         end
      end
   end

   assign sum     = sum_q;
   assign max_abs = max_q;
   assign max_idx = idx_q;

endmodule

// File: tb/tb_abs_frame_accumulator.sv
// Directed bench with a result scoreboard for abs_frame_accumulator (COUNT=8).
module tb_abs_frame_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        busy;
   logic        done;
   logic [10:0] sum;
   logic [7:0]  max_abs;
   logic [2:0]  max_idx;

   typedef logic [7:0] frame_t [8];
   typedef struct {
      logic [10:0] sum;
      logic [7:0]  mx;
      logic [2:0]  idx;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;

   abs_frame_accumulator #(.COUNT(8), .SUM_W(11)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .max_abs  (max_abs),
      .max_idx  (max_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input frame_t s);
      exp_t e;
      int   total = 0;
      int   best  = 0;
      int   bidx  = 0;
      for (int i = 0; i < 8; i++) begin
         int v = int'($signed(s[i]));
         int m = (v < 0) ? -v : v;
         total += m;
         if (m > best) begin
            best = m;
            bidx = i;
         end
      end
      e.sum = 11'(total);
      e.mx  = 8'(best);
      e.idx = 3'(bidx);
      return e;
   endfunction

   task automatic run_frame(input string tag, input frame_t s, input bit stall,
                            input int start_at, input int exp_lat);
      exp_t e;
      int   cyc = 0;
      int   dc0;
      sb.push_back(model(s));
      dc0   = done_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      check({tag, " busy"}, 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) begin
         if (stall && i > 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            step();
            cyc++;
         end
         in_valid = 1'b1;
         in_data  = s[i];
         start    = (i == start_at);
         step();
         cyc++;
         start = 1'b0;
         if (i < 7) check({tag, " early done"}, 32'(done), 32'd0);
      end
      in_valid = 1'b0;
      while (done !== 1'b1 && cyc < 40) begin
         step();
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
      check({tag, " done"}, 32'(done), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, " sum"}, 32'(sum), 32'(e.sum));
         check({tag, " max_abs"}, 32'(max_abs), 32'(e.mx));
         check({tag, " max_idx"}, 32'(max_idx), 32'(e.idx));
      end else begin
         check({tag, " scoreboard size"}, 32'(sb.size()), 32'd1);
      end
      step();
      check({tag, " done width"}, 32'(done), 32'd0);
      check({tag, " done pulses"}, 32'(done_cnt - dc0), 32'd1);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      frame_t f_basic, f_tie, f_full, f_after;
      exp_t   hold_e;
      int     dc0;
      f_basic = '{8'h0B, 8'hDB, 8'h00, 8'hFF, 8'h8B, 8'h05, 8'h80, 8'h14};
      f_tie   = '{8'h05, 8'hF7, 8'h09, 8'h03, 8'hF7, 8'h00, 8'h01, 8'h02};
      f_full  = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
      f_after = '{8'h01, 8'h7F, 8'h81, 8'h00, 8'hC0, 8'h7F, 8'h02, 8'hFE};

      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      step();
      step();
      check("reset in_ready", 32'(in_ready), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset sum", 32'(sum), 32'd0);
      check("reset max_abs", 32'(max_abs), 32'd0);
      check("reset max_idx", 32'(max_idx), 32'd0);
      rst_n = 1'b1;
      step();

      // Fixed expectations cross-check the model for the basic frame.
      hold_e = model(f_basic);
      check("model basic sum", 32'(hold_e.sum), 32'd319);
      check("model basic idx", 32'(hold_e.idx), 32'd6);

      run_frame("basic", f_basic, 1'b0, -1, 8);
      run_frame("stall", f_basic, 1'b1, -1, 15);
      run_frame("tie", f_tie, 1'b0, -1, 8);
      run_frame("full", f_full, 1'b0, -1, 8);
      run_frame("ignored start", f_tie, 1'b0, 3, 8);

      // Frame aborted by asynchronous reset after four samples.
      dc0   = done_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = f_full[i];
         step();
      end
      in_valid = 1'b0;
      check("pre-reset sum", 32'(sum), 32'd512);
      #2 rst_n = 1'b0;
      #1;
      check("async sum", 32'(sum), 32'd0);
      check("async max_abs", 32'(max_abs), 32'd0);
      check("async max_idx", 32'(max_idx), 32'd0);
      check("async in_ready", 32'(in_ready), 32'd0);
      check("async busy", 32'(busy), 32'd0);
      check("async done", 32'(done), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check("aborted no done", 32'(done_cnt - dc0), 32'd0);

      run_frame("after reset", f_after, 1'b0, -1, 8);

      hold_e = model(f_after);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom);
         in_data  = 8'($urandom);
         step();
         check("hold sum", 32'(sum), 32'(hold_e.sum));
         check("hold max_abs", 32'(max_abs), 32'(hold_e.mx));
         check("hold max_idx", 32'(max_idx), 32'(hold_e.idx));
         check("hold in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
